// File: rtl/alu_writeback.sv
// ALU result writeback: queues (y1, y2) results in a small FIFO and drains them to a
// single-write-port register file. Optional flag outputs under ALU_WB_FLAGS_EN.
module alu_writeback #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_dual,
  input  logic [ADDR_W-1:0] in_rd1,
  input  logic [ADDR_W-1:0] in_rd2,
  input  logic [DATA_W-1:0] in_y1,
  input  logic [DATA_W-1:0] in_y2,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy
`ifdef ALU_WB_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_n
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic {LO, HI} phase_t;

  logic              dual_mem [DEPTH];
  logic [ADDR_W-1:0] rd1_mem  [DEPTH];
  logic [ADDR_W-1:0] rd2_mem  [DEPTH];
  logic [DATA_W-1:0] y1_mem   [DEPTH];
  logic [DATA_W-1:0] y2_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_next;
  phase_t           phase;
  logic             push, pop, nonempty;

  assign nonempty   = (count != '0);
  assign push       = in_valid & in_ready;
  // Head leaves the FIFO after its last (or only) write.
  assign pop        = nonempty & ((phase == HI) | ~dual_mem[rd_ptr]);
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  // FIFO storage, no reset needed: occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      dual_mem[wr_ptr] <= in_dual;
      rd1_mem[wr_ptr]  <= in_rd1;
      rd2_mem[wr_ptr]  <= in_rd2;
      y1_mem[wr_ptr]   <= in_y1;
      y2_mem[wr_ptr]   <= in_y2;
    end
  end

  // Pointers, occupancy and the LO/HI drain sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      phase    <= LO;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      busy     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count    <= count_next;
      busy     <= (count_next != '0);
      in_ready <= (count_next != FULL);
      if (!nonempty) begin
        rf_we <= 1'b0;
      end else begin
        case (phase)
          LO: begin
            rf_we    <= (rd1_mem[rd_ptr] != '0);
            rf_waddr <= rd1_mem[rd_ptr];
            rf_wdata <= y1_mem[rd_ptr];
            if (dual_mem[rd_ptr]) phase <= HI;
          end
          HI: begin
            rf_we    <= (rd2_mem[rd_ptr] != '0);
            rf_waddr <= rd2_mem[rd_ptr];
            rf_wdata <= y2_mem[rd_ptr];
            phase    <= LO;
          end
          default: phase <= LO;
        endcase
      end
    end
  end

`ifdef ALU_WB_FLAGS_EN
  // Flags track the most recently accepted result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (push) begin
      flag_z <= (in_y1 == '0) & (~in_dual | (in_y2 == '0));
      flag_n <= in_dual ? in_y2[DATA_W-1] : in_y1[DATA_W-1];
    end
  end
`else
  // Flag outputs not built in this configuration.
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: vector table plus back-pressure, reset and flag sequences.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_dual;
  logic [4:0]  in_rd1, in_rd2;
  logic [31:0] in_y1, in_y2;
  logic        rf_we, busy;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef ALU_WB_FLAGS_EN
  logic        flag_z, flag_n;
`endif

  alu_writeback dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_dual(in_dual),
    .in_rd1(in_rd1), .in_rd2(in_rd2), .in_y1(in_y1), .in_y2(in_y2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
`ifdef ALU_WB_FLAGS_EN
    , .flag_z(flag_z), .flag_n(flag_n)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic v, input logic d, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid = v; in_dual = d; in_rd1 = r1; in_rd2 = r2; in_y1 = a; in_y2 = b;
  endtask

  typedef struct {
    logic        valid, dual;
    logic [4:0]  rd1, rd2;
    logic [31:0] y1, y2;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        ready, busy;
  } vec_t;

  vec_t vecs[14];
  logic [4:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  int          nwrites;

  initial begin
    // valid dual rd1 rd2 y1 y2 | we waddr wdata ready busy  (outputs after the edge)
    vecs[0]  = '{1'b1, 1'b0, 5'd3, 5'd0, 32'h1234, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 5'd0, 5'd0, 32'h0,    32'h0,    1'b1, 5'd3, 32'h1234, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 5'd4, 5'd5, 32'hAAAA, 32'h5555, 1'b0, 5'd3, 32'h1234, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 5'd0, 5'd0, 32'h0,    32'h0,    1'b1, 5'd4, 32'hAAAA, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 5'd0, 5'd0, 32'h0,    32'h0,    1'b1, 5'd5, 32'h5555, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 5'd0, 5'd0, 32'h0,    32'h0,    1'b0, 5'd5, 32'h5555, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 5'd0, 5'd0, 32'hFFFF, 32'h0,    1'b0, 5'd5, 32'h5555, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 5'd7, 5'd0, 32'h77,   32'h0,    1'b0, 5'd0, 32'hFFFF, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 5'd0, 5'd0, 32'h0,    32'h0,    1'b1, 5'd7, 32'h77,   1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 5'd1, 5'd9, 32'h11,   32'hDEAD, 1'b0, 5'd7, 32'h77,   1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 5'd2, 5'd0, 32'h22,   32'h0,    1'b1, 5'd1, 32'h11,   1'b1, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 5'd3, 5'd0, 32'h33,   32'h0,    1'b1, 5'd2, 32'h22,   1'b1, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 5'd0, 5'd0, 32'h0,    32'h0,    1'b1, 5'd3, 32'h33,   1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 5'd0, 5'd0, 32'h0,    32'h0,    1'b0, 5'd3, 32'h33,   1'b1, 1'b0};

    drive(1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_we",    64'(rf_we),    64'(0));
    chk("reset_waddr", 64'(rf_waddr), 64'(0));
    chk("reset_wdata", 64'(rf_wdata), 64'(0));
    chk("reset_ready", 64'(in_ready), 64'(1));
    chk("reset_busy",  64'(busy),     64'(0));
    rst = 1'b0;

    // Table: latency, dual pairs, r0 suppression, sustained single results.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].valid, vecs[i].dual, vecs[i].rd1, vecs[i].rd2, vecs[i].y1, vecs[i].y2);
      @(posedge clk); #1;
      chk($sformatf("v%0d_we", i),    64'(rf_we),    64'(vecs[i].we));
      chk($sformatf("v%0d_waddr", i), 64'(rf_waddr), 64'(vecs[i].waddr));
      chk($sformatf("v%0d_wdata", i), 64'(rf_wdata), 64'(vecs[i].wdata));
      chk($sformatf("v%0d_ready", i), 64'(in_ready), 64'(vecs[i].ready));
      chk($sformatf("v%0d_busy", i),  64'(busy),     64'(vecs[i].busy));
    end

    // Back-to-back duals with valid held: only cycles 1,2,4,6,8,10 are accepted.
    foreach (vecs[i]) ;
    for (int k = 1; k <= 10; k++) begin
      if (k == 1 || k % 2 == 0) begin
        exp_addr.push_back(5'(2*k+1)); exp_data.push_back(32'hA000_0000 | 32'(k));
        exp_addr.push_back(5'(2*k+2)); exp_data.push_back(32'hB000_0000 | 32'(k));
      end
    end
    nwrites = 0;
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, 1'b1, 5'(2*k+1), 5'(2*k+2), 32'hA000_0000 | 32'(k), 32'hB000_0000 | 32'(k));
      @(posedge clk); #1;
      chk($sformatf("bp_ready_%0d", k), 64'(in_ready), 64'((k == 1 || k % 2 == 1) ? 1 : 0));
      if (rf_we) begin
        nwrites++;
        if (exp_addr.size() == 0) chk("bp_extra_write", 64'(1), 64'(0));
        else begin
          chk($sformatf("bp_addr_%0d", nwrites), 64'(rf_waddr), 64'(exp_addr.pop_front()));
          chk($sformatf("bp_data_%0d", nwrites), 64'(rf_wdata), 64'(exp_data.pop_front()));
        end
      end
    end
    drive(1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (rf_we) begin
        nwrites++;
        if (exp_addr.size() == 0) chk("bp_extra_write", 64'(1), 64'(0));
        else begin
          chk($sformatf("bp_addr_%0d", nwrites), 64'(rf_waddr), 64'(exp_addr.pop_front()));
          chk($sformatf("bp_data_%0d", nwrites), 64'(rf_wdata), 64'(exp_data.pop_front()));
        end
      end
    end
    chk("bp_total_writes", 64'(nwrites), 64'(12));
    chk("bp_busy_done",    64'(busy),    64'(0));

    // Reset between the two writes of a dual.
    drive(1'b1, 1'b1, 5'd10, 5'd11, 32'hC0DE, 32'hBEEF);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("mid_first_we",   64'(rf_we),    64'(1));
    chk("mid_first_addr", 64'(rf_waddr), 64'(10));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_we",    64'(rf_we),    64'(0));
    chk("mid_rst_ready", 64'(in_ready), 64'(1));
    chk("mid_rst_busy",  64'(busy),     64'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("mid_no_second_%0d", c), 64'(rf_we), 64'(0));
    end

`ifdef ALU_WB_FLAGS_EN
    chk("flag_z_reset", 64'(flag_z), 64'(0));
    chk("flag_n_reset", 64'(flag_n), 64'(0));
    drive(1'b1, 1'b0, 5'd6, 5'd0, 32'h0, 32'h5);
    @(posedge clk); #1;
    chk("flag_z_single", 64'(flag_z), 64'(1));
    chk("flag_n_single", 64'(flag_n), 64'(0));
    drive(1'b1, 1'b1, 5'd6, 5'd7, 32'h0, 32'h8000_0000);
    @(posedge clk); #1;
    chk("flag_z_dual", 64'(flag_z), 64'(0));
    chk("flag_n_dual", 64'(flag_n), 64'(1));
    drive(1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
    repeat (4) @(posedge clk);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
